vc_out_sched: RTL and testbench

//  Synchronous scheduler for one router output port shared by VCN virtual channels.

---
 rtl/noc_vc_pkg.sv | 17 +
 rtl/vc_rr_arb.sv | 32 +++
 rtl/vc_out_sched.sv | 128 ++++++++++++
 tb/tb_vc_out_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_pkg.sv
// Shared flit-type encodings and helpers for the VC output scheduler slice.
package noc_vc_pkg;

    localparam logic [2:0] FT_HOF = 3'b001;
    localparam logic [2:0] FT_BOF = 3'b010;
    localparam logic [2:0] FT_EOF = 3'b100;

    // Index of the set bit of a one-hot vector (0 when none set).
    function automatic int onehot2bin(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/vc_rr_arb.sv
// Combinational round-robin select: first eligible VC at or above ptr, wrapping.
module vc_rr_arb
    import noc_vc_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] sel
);

    logic found;
    int   idx;

    // Walk N positions starting at ptr; the first eligible one wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
            end
        end
        sel = PW'(onehot2bin(32'(gnt)));
    end

endmodule

// File: rtl/vc_out_sched.sv
// Output-port VC scheduler: per-VC credits, round-robin pick, 1-deep output stage,
// packet ownership tracking and sticky protocol error.
module vc_out_sched
    import noc_vc_pkg::*;
#(
    parameter int VCN = 4,
    parameter int FT  = 3,
    parameter int CRD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VCN-1:0]    req,
    input  logic [VCN*FT-1:0] req_ft,
    output logic [VCN-1:0]    gnt,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [VCN-1:0]    out_vc,
    output logic [FT-1:0]     out_ft,
    input  logic [VCN-1:0]    credit,
    output logic [VCN-1:0]    afc,
    output logic [VCN-1:0]    vc_busy,
    output logic              err
);

    localparam int CW = $clog2(CRD + 1);
    localparam int PW = (VCN > 1) ? $clog2(VCN) : 1;

    logic [CW-1:0]  cnt     [VCN];
    logic [CW-1:0]  cnt_nxt [VCN];
    logic [PW-1:0]  rr_ptr, sel;
    logic [VCN-1:0] elig, arb_gnt, busy_nxt;
    logic [FT-1:0]  sel_ft;
    logic           load, crd_ovf, busy_err, hof, bof, eof;

    vc_rr_arb #(.N(VCN)) u_arb (
        .elig (elig),
        .ptr  (rr_ptr),
        .gnt  (arb_gnt),
        .sel  (sel)
    );

    // Eligibility and load decision; the stage may refill in the cycle it drains.
    always_comb begin
        for (int i = 0; i < VCN; i++)
            elig[i] = req[i] && (cnt[i] != '0);
        load   = (|elig) && (!out_vld || out_rdy) && !rst;
        gnt    = load ? arb_gnt : '0;
        sel_ft = req_ft[int'(sel)*FT +: FT];
    end

    // Credit arithmetic: spend on grant, refund on pulse, saturate and flag overflow.
    always_comb begin
        crd_ovf = 1'b0;
        for (int i = 0; i < VCN; i++) begin
            cnt_nxt[i] = cnt[i];
            case ({gnt[i], credit[i]})
                2'b10: cnt_nxt[i] = cnt[i] - 1'b1;
                2'b01: begin
                    if (cnt[i] == CW'(CRD)) crd_ovf = 1'b1;
                    else cnt_nxt[i] = cnt[i] + 1'b1;
                end
                default: cnt_nxt[i] = cnt[i];
            endcase
        end
    end

    // Packet ownership: HOF claims the VC, EOF releases it, HOF|EOF leaves it alone.
    always_comb begin
        hof      = (sel_ft & FT'(FT_HOF)) != '0;
        bof      = (sel_ft & FT'(FT_BOF)) != '0;
        eof      = (sel_ft & FT'(FT_EOF)) != '0;
        busy_nxt = vc_busy;
        busy_err = 1'b0;
        if (load) begin
            if (hof && !eof) begin
                if (vc_busy[sel]) busy_err = 1'b1;
                busy_nxt[sel] = 1'b1;
            end else if (eof && !hof) begin
                busy_nxt[sel] = 1'b0;
            end
            if (bof && !vc_busy[sel]) busy_err = 1'b1;
        end
    end

    // Credit counters and registered all-full-credit-spent flags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VCN; i++) begin
            if (rst) begin
                cnt[i] <= CW'(CRD);
                afc[i] <= 1'b0;
            end else begin
                cnt[i] <= cnt_nxt[i];
                afc[i] <= (cnt_nxt[i] == '0);
            end
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_vc  <= '0;
            out_ft  <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            out_vld <= 1'b1;
            out_vc  <= gnt;
            out_ft  <= sel_ft;
            rr_ptr  <= (int'(sel) == VCN - 1) ? '0 : sel + 1'b1;
        end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
            out_vc  <= '0;
            out_ft  <= '0;
        end
    end

    // Ownership state and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            vc_busy <= '0;
            err     <= 1'b0;
        end else begin
            vc_busy <= busy_nxt;
            err     <= err | crd_ovf | busy_err;
        end
    end

endmodule

// File: tb/tb_vc_out_sched.sv
// Directed bench for vc_out_sched with a grant scoreboard.
module tb_vc_out_sched;

    localparam logic [2:0] HOF = 3'b001;
    localparam logic [2:0] BOF = 3'b010;
    localparam logic [2:0] EOF = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, gnt, out_vc, credit, afc, vc_busy;
    logic [11:0] req_ft;
    logic [2:0]  out_ft;
    logic        out_vld, out_rdy, err;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    vc_out_sched #(.VCN(4), .FT(3), .CRD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_ft  (req_ft),
        .gnt     (gnt),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_vc  (out_vc),
        .out_ft  (out_ft),
        .credit  (credit),
        .afc     (afc),
        .vc_busy (vc_busy),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check any grant against the scoreboard at negedge, then advance.
    task automatic tick();
        logic [3:0] e;
        @(negedge clk);
        if (gnt !== 4'b0000) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL gnt_unexpected obs=%0h exp=none", gnt);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt_order", 32'(gnt), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; credit = '0; out_rdy = 1'b1; req_ft = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_ft = '0; credit = '0; out_rdy = 1'b0;
        #1;
        do_reset();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_vc",  out_vc, 0);
        chk("rst_out_ft",  out_ft, 0);
        chk("rst_afc",     afc, 0);
        chk("rst_busy",    vc_busy, 0);
        chk("rst_err",     err, 0);
        chk("rst_ptr",     dut.rr_ptr, 0);

        // 1: all VCs request, round-robin order, one grant per cycle
        req = 4'b1111; req_ft = {BOF, BOF, BOF, BOF}; out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(4'b0001 << (k % 4));
        for (int k = 0; k < 8; k++) tick();
        drain("t1_drain");
        chk("t1_afc",    afc, 0);
        chk("t1_vld",    out_vld, 1);
        chk("t1_vc",     out_vc, 4'b1000);
        chk("t1_ft",     out_ft, BOF);
        chk("t1_err",    err, 1);
        req = '0;
        tick();
        chk("t1_vld_off", out_vld, 0);
        chk("t1_vc_off",  out_vc, 0);

        // 2: single VC exhausts credits, then a refund allows one more grant
        do_reset();
        req = 4'b0001; req_ft = {9'b0, BOF};
        for (int k = 0; k < 4; k++) exp_q.push_back(4'b0001);
        for (int k = 0; k < 4; k++) tick();
        drain("t2_drain4");
        chk("t2_afc_set", afc, 4'b0001);
        for (int k = 0; k < 3; k++) tick();
        chk("t2_afc_hold", afc, 4'b0001);
        credit = 4'b0001;
        tick();
        credit = '0;
        chk("t2_afc_clr", afc, 0);
        exp_q.push_back(4'b0001);
        tick();
        drain("t2_drain5");
        chk("t2_afc_again", afc, 4'b0001);
        req = '0;

        // 3: backpressure holds the stage, then drain and refill in one cycle
        do_reset();
        req = 4'b0001; req_ft = {9'b0, HOF};
        exp_q.push_back(4'b0001);
        tick();
        out_rdy = 1'b0; req_ft = {9'b0, EOF};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_vld", out_vld, 1);
            chk("t3_hold_vc",  out_vc, 4'b0001);
            chk("t3_hold_ft",  out_ft, HOF);
        end
        out_rdy = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        drain("t3_drain");
        chk("t3_vld_kept", out_vld, 1);
        chk("t3_ft_new",   out_ft, EOF);
        chk("t3_busy",     vc_busy, 0);
        req = '0;
        tick();
        chk("t3_vld_off", out_vld, 0);

        // 4: simultaneous spend and refund, then overflow at full credit
        do_reset();
        req = 4'b0100; req_ft = {3'b0, HOF | EOF, 6'b0};
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0100);
        tick(); tick();
        chk("t4_cnt2", dut.cnt[2], 2);
        exp_q.push_back(4'b0100);
        credit = 4'b0100;
        tick();
        credit = '0; req = '0;
        drain("t4_drain");
        chk("t4_cnt_same", dut.cnt[2], 2);
        chk("t4_err0", err, 0);
        credit = 4'b0100;
        tick(); tick();
        chk("t4_cnt_full", dut.cnt[2], 4);
        chk("t4_err_pre", err, 0);
        tick();
        credit = '0;
        chk("t4_cnt_sat", dut.cnt[2], 4);
        chk("t4_err_ovf", err, 1);

        // 5: packet ownership on VC1 (credits refunded alongside each grant)
        do_reset();
        req = 4'b0010; credit = 4'b0010;
        req_ft = {6'b0, HOF, 3'b0};       exp_q.push_back(4'b0010); tick();
        chk("t5_hof", vc_busy, 4'b0010);
        req_ft = {6'b0, BOF, 3'b0};       exp_q.push_back(4'b0010); tick();
        chk("t5_bof", vc_busy, 4'b0010);
        req_ft = {6'b0, EOF, 3'b0};       exp_q.push_back(4'b0010); tick();
        chk("t5_eof", vc_busy, 0);
        chk("t5_err_clean", err, 0);
        req_ft = {6'b0, HOF | EOF, 3'b0}; exp_q.push_back(4'b0010); tick();
        chk("t5_single_idle", vc_busy, 0);
        req_ft = {6'b0, HOF, 3'b0};       exp_q.push_back(4'b0010); tick();
        req_ft = {6'b0, HOF | EOF, 3'b0}; exp_q.push_back(4'b0010); tick();
        chk("t5_single_busy", vc_busy, 4'b0010);
        chk("t5_err_single", err, 0);
        req_ft = {6'b0, HOF, 3'b0};       exp_q.push_back(4'b0010); tick();
        chk("t5_err_dup_hof", err, 1);
        chk("t5_busy_kept", vc_busy, 4'b0010);
        drain("t5_drain");
        chk("t5_cnt1", dut.cnt[1], 4);
        req = '0; credit = '0;

        // 6: reset mid-stream drops the held flit and restores everything
        do_reset();
        req = 4'b1111; req_ft = {HOF | EOF, HOF | EOF, HOF | EOF, HOF};
        credit = 4'b1000;
        exp_q.push_back(4'b0001); tick();
        credit = '0;
        exp_q.push_back(4'b0010); tick();
        exp_q.push_back(4'b0100); tick();
        drain("t6_drain");
        chk("t6_pre_vld",  out_vld, 1);
        chk("t6_pre_err",  err, 1);
        chk("t6_pre_busy", vc_busy, 4'b0001);
        chk("t6_pre_ptr",  dut.rr_ptr, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        chk("t6_vld",  out_vld, 0);
        chk("t6_vc",   out_vc, 0);
        chk("t6_busy", vc_busy, 0);
        chk("t6_err",  err, 0);
        chk("t6_ptr",  dut.rr_ptr, 0);
        chk("t6_afc",  afc, 0);
        for (int i = 0; i < 4; i++) chk("t6_cnt", dut.cnt[i], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
